// File: rtl/tms12_master_driver_pkg.sv
// Shared types for the TestMasterSlave12 master driver: FSM states, widths and
// the transaction data generator used by both slave channels.
package tms12_driver_types;

  localparam int CNT_W  = 4;
  localparam int TXC_W  = 16;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    DRV_IDLE,
    DRV_SEND1,
    DRV_SEND2,
    DRV_WAIT,
    DRV_GAP,
    DRV_DONE
  } drv_state_t;

  // Transaction idx drives base+2*idx on channel 1 and base+2*idx+1 on channel 2.
  function automatic logic [DATA_W-1:0] tx_data(input logic [DATA_W-1:0] base,
                                                input logic [TXC_W-1:0]  idx,
                                                input logic              odd);
    return base + {{(DATA_W - TXC_W - 1){1'b0}}, idx, odd};
  endfunction

endpackage

// File: rtl/tms12_delay_counter.sv
// Loadable 4-bit down-counter with a zero flag; shared between the response
// wait and the inter-transaction gap of the master driver.
module tms12_delay_counter
  import tms12_driver_types::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // A load wins over a decrement; the counter saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/tms12_master_driver.sv
// Master-side driver for the TestMasterSlave12 slave: issues a burst of NUM_TX
// strobed transactions and accumulates a wrap-around checksum of the responses.
module tms12_master_driver
  import tms12_driver_types::*;
#(
  parameter int unsigned NUM_TX   = 16,
  parameter int unsigned RESP_LAT = 2,
  parameter int unsigned GAP      = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] base_i,
  output logic [DATA_W-1:0] m_out_o,
  output logic              m_out_sync_o,
  output logic [DATA_W-1:0] m_out2_o,
  output logic              m_out2_sync_o,
  input  logic [DATA_W-1:0] m_in_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [TXC_W-1:0]  tx_count_o,
  output logic [DATA_W-1:0] checksum_o
);

  localparam logic [TXC_W-1:0] NUM_TX_L  = TXC_W'(NUM_TX);
  localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESP_LAT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  drv_state_t        state_q, state_d;
  logic [DATA_W-1:0] base_l_q, base_l_d;
  logic [TXC_W-1:0]  tx_count_q, tx_count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] m_out_q, m_out_d;
  logic [DATA_W-1:0] m_out2_q, m_out2_d;
  logic              m_out_sync_q, m_out_sync_d;
  logic              m_out2_sync_q, m_out2_sync_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_zero;

  tms12_delay_counter u_delay (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    base_l_d     = base_l_q;
    tx_count_d   = tx_count_q;
    checksum_d   = checksum_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      DRV_IDLE: begin
        if (start_i) begin
          base_l_d   = base_i;
          tx_count_d = '0;
          checksum_d = '0;
          state_d    = DRV_SEND1;
        end
      end
      DRV_SEND1: state_d = DRV_SEND2;
      DRV_SEND2: begin
        cnt_load     = 1'b1;
        cnt_load_val = RESP_LOAD;
        state_d      = DRV_WAIT;
      end
      DRV_WAIT: begin
        if (cnt_zero) begin
          checksum_d = checksum_q + m_in_i;
          tx_count_d = tx_count_q + TXC_W'(1);
          if (tx_count_d == NUM_TX_L) begin
            state_d = DRV_DONE;
          end else if (GAP > 0) begin
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
            state_d      = DRV_GAP;
          end else begin
            state_d = DRV_SEND1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DRV_GAP: begin
        if (cnt_zero) begin
          state_d = DRV_SEND1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DRV_DONE: begin
        if (!start_i) begin
          state_d = DRV_IDLE;
        end
      end
      default: state_d = DRV_IDLE;
    endcase

    // Outputs are registered against the next state so they line up with it.
    m_out_d       = m_out_q;
    m_out2_d      = m_out2_q;
    m_out_sync_d  = (state_d == DRV_SEND1);
    m_out2_sync_d = (state_d == DRV_SEND2);
    if (m_out_sync_d) begin
      m_out_d = tx_data(base_l_d, tx_count_d, 1'b0);
    end
    if (m_out2_sync_d) begin
      m_out2_d = tx_data(base_l_d, tx_count_d, 1'b1);
    end
    busy_d = (state_d inside {DRV_SEND1, DRV_SEND2, DRV_WAIT, DRV_GAP});
    done_d = (state_d == DRV_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= DRV_IDLE;
      base_l_q      <= '0;
      tx_count_q    <= '0;
      checksum_q    <= '0;
      m_out_q       <= '0;
      m_out2_q      <= '0;
      m_out_sync_q  <= 1'b0;
      m_out2_sync_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_l_q      <= base_l_d;
      tx_count_q    <= tx_count_d;
      checksum_q    <= checksum_d;
      m_out_q       <= m_out_d;
      m_out2_q      <= m_out2_d;
      m_out_sync_q  <= m_out_sync_d;
      m_out2_sync_q <= m_out2_sync_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign m_out_o       = m_out_q;
  assign m_out2_o      = m_out2_q;
  assign m_out_sync_o  = m_out_sync_q;
  assign m_out2_sync_o = m_out2_sync_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign tx_count_o    = tx_count_q;
  assign checksum_o    = checksum_q;

endmodule
